// File: rtl/demux_seq_pkg.sv
// Shared encodings and the position-step rule for the LED demux sequencer.
// The RANDOM option (DEMUX_RANDOM_MODE_EN) reuses the MODE_HOLD encoding.
package demux_seq_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD       = 2'b00,
      MODE_CHASE_UP   = 2'b01,
      MODE_CHASE_DOWN = 2'b10,
      MODE_PING_PONG  = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2
   } state_t;

   typedef struct packed {
      logic       dir_down;
      logic [1:0] pos;
   } step_t;

`ifdef DEMUX_RANDOM_MODE_EN
   localparam logic [7:0] LFSR_RESET = 8'h00;
`endif

   // Deterministic next position/direction. Every non-ping-pong step forces direction up.
   function automatic step_t next_step(input mode_t mode, input step_t cur);
      step_t nxt;
      nxt.dir_down = 1'b0;
      nxt.pos      = cur.pos;
      case (mode)
         MODE_CHASE_UP:   nxt.pos = cur.pos + 2'd1;
         MODE_CHASE_DOWN: nxt.pos = cur.pos - 2'd1;
         MODE_PING_PONG: begin
            if (!cur.dir_down) begin
               if (cur.pos == 2'd3) begin
                  nxt.dir_down = 1'b1;
                  nxt.pos      = 2'd2;
               end else begin
                  nxt.pos = cur.pos + 2'd1;
               end
            end else begin
               if (cur.pos == 2'd0) begin
                  nxt.pos = 2'd1;
               end else begin
                  nxt.dir_down = 1'b1;
                  nxt.pos      = cur.pos - 2'd1;
               end
            end
         end
         default: ;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Free-running divider: o_tick is high for the one cycle the counter sits at TICK_DIV-1.
module seq_tick_gen #(
   parameter int TICK_DIV = 3000000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int             CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)          cnt <= '0;
      else if (cnt == LAST)  cnt <= '0;
      else                   cnt <= cnt + CW'(1);
   end

   assign o_tick = (cnt == LAST);

endmodule

// File: rtl/demux_led_sequencer.sv
// Mode-driven LED sequencer feeding a 4-way demux (select + data).
// Optional macro DEMUX_RANDOM_MODE_EN turns mode 00 into an LFSR-driven RANDOM mode.
module demux_led_sequencer
   import demux_seq_pkg::*;
#(
   parameter int TICK_DIV       = 3000000,
   parameter int DEBOUNCE_LIMIT = 250000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_switch_1,
   input  logic i_switch_2,
   output logic o_sel_1,
   output logic o_sel_2,
   output logic o_data
);

   localparam int             DB_W    = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LIMIT - 1);

   logic            tick;
   logic [1:0]      raw;
   logic [1:0]      sw_db;
   logic [DB_W-1:0] db_cnt [2];
   state_t          state;
   step_t           cur;
   step_t           nxt;
   logic            data_q;

   seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .o_tick  (tick)
   );

   assign raw = {i_switch_2, i_switch_1};

   // NOTE: the two debounce counters are plain flops, so they are reset like any other state.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sw_db <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (raw[i] == sw_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               sw_db[i]  <= raw[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

`ifdef DEMUX_RANDOM_MODE_EN
   logic [7:0] lfsr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) lfsr <= LFSR_RESET;
      else          lfsr <= {lfsr[6:0], ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3])};
   end
`endif

   // NOTE: nxt gets a full default first, so no path through this block can infer a latch.
   always_comb begin
      nxt = next_step(mode_t'(sw_db), cur);
`ifdef DEMUX_RANDOM_MODE_EN
      if (mode_t'(sw_db) == MODE_HOLD) begin
         nxt.dir_down = 1'b0;
         nxt.pos      = (lfsr[1:0] == cur.pos) ? cur.pos + 2'd1 : lfsr[1:0];
      end
`endif
   end

   // Position only moves on the OFF->ON edge, so select is stable whenever data is high.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state  <= S_IDLE;
         data_q <= 1'b0;
         cur    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               state  <= S_ON;
               data_q <= 1'b1;
            end
            S_ON: if (tick) begin
               state  <= S_OFF;
               data_q <= 1'b0;
            end
            S_OFF: if (tick) begin
               state  <= S_ON;
               data_q <= 1'b1;
               cur    <= nxt;
            end
            default: begin
               state  <= S_IDLE;
               data_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_sel_1 = cur.pos[0];
   assign o_sel_2 = cur.pos[1];
   assign o_data  = data_q;

endmodule

// File: tb/tb_demux_led_sequencer.sv
// Self-checking bench for demux_led_sequencer with a step-level reference model.
module tb_demux_led_sequencer;

   localparam int TICK_DIV       = 3;
   localparam int DEBOUNCE_LIMIT = 4;
   localparam int HOLD_FOREVER   = 99;

   logic i_clk      = 1'b0;
   logic i_rst_n    = 1'b0;
   logic i_switch_1 = 1'b0;
   logic i_switch_2 = 1'b0;
   logic o_sel_1, o_sel_2, o_data;

   int checks   = 0;
   int failures = 0;

   // Reference model state: LED position, ping-pong direction, accepted mode, raw switches.
   int         m_pos  = 0;
   bit         m_down = 1'b0;
   int         m_mode = 0;
   logic [1:0] raw    = 2'b00;

   always #5 i_clk = ~i_clk;

   demux_led_sequencer #(
      .TICK_DIV       (TICK_DIV),
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
   ) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_switch_1 (i_switch_1),
      .i_switch_2 (i_switch_2),
      .o_sel_1    (o_sel_1),
      .o_sel_2    (o_sel_2),
      .o_data     (o_data)
   );

   function automatic logic [7:0] sel();
      return {6'd0, o_sel_2, o_sel_1};
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_raw(input logic [1:0] v);
      i_switch_1 = v[0];
      i_switch_2 = v[1];
      raw        = v;
   endtask

   // One step of the LED walk, straight from the mode rules.
   function automatic void model_step();
      case (m_mode)
         1: begin m_pos = (m_pos + 1) % 4; m_down = 1'b0; end
         2: begin m_pos = (m_pos + 3) % 4; m_down = 1'b0; end
         3: begin
            if (!m_down) begin
               if (m_pos == 3) begin m_down = 1'b1; m_pos = 2; end
               else m_pos = m_pos + 1;
            end else begin
               if (m_pos == 0) begin m_down = 1'b0; m_pos = 1; end
               else m_pos = m_pos - 1;
            end
         end
         default: m_down = 1'b0;
      endcase
   endfunction

   // Called right after an OFF->ON edge: data must be lit and select must show the new position.
   task automatic expect_step(input string tag);
      int  prev = m_pos;
      bit  predicted = 1'b1;
`ifdef DEMUX_RANDOM_MODE_EN
      if (m_mode == 0) begin
         check({tag, "_moved"}, 8'(sel() != 8'(prev)), 8'd1);
         m_pos     = int'(sel());
         m_down    = 1'b0;
         predicted = 1'b0;
      end
`endif
      if (predicted) model_step();
      check({tag, "_data_on"}, 8'(o_data), 8'd1);
      if (predicted) check({tag, "_sel"}, sel(), 8'(m_pos));
   endtask

   // One full ON+OFF step starting just after the edge that entered ON.
   // The switches show sw for 'hold' edges, then return to their previous value.
   task automatic do_step(input logic [1:0] sw, input int hold, input string tag);
      logic [1:0] prev_raw = raw;
      drive_raw(sw);
      for (int i = 1; i <= 2 * TICK_DIV; i++) begin
         tick();
         if (i == hold) drive_raw(prev_raw);
         if (i < TICK_DIV) begin
            check({tag, "_on_data"}, 8'(o_data), 8'd1);
            check({tag, "_on_sel"}, sel(), 8'(m_pos));
         end else if (i < 2 * TICK_DIV) begin
            check({tag, "_off_data"}, 8'(o_data), 8'd0);
            check({tag, "_off_sel"}, sel(), 8'(m_pos));
         end else begin
            if (hold >= DEBOUNCE_LIMIT) m_mode = int'(sw);
            expect_step(tag);
         end
      end
   endtask

   // Hold reset for 'cycles' edges, release, and walk through the first ON/OFF/ON boundary.
   task automatic do_reset(input int cycles, input string tag);
      drive_raw(2'b00);
      i_rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         check({tag, "_rst_data"}, 8'(o_data), 8'd0);
         check({tag, "_rst_sel"}, sel(), 8'd0);
      end
      i_rst_n = 1'b1;
      m_pos   = 0;
      m_down  = 1'b0;
      m_mode  = 0;
      tick();
      check({tag, "_first_on"}, 8'(o_data), 8'd1);
      check({tag, "_first_sel"}, sel(), 8'd0);
      tick();
      check({tag, "_still_on"}, 8'(o_data), 8'd1);
      tick();
      check({tag, "_first_tick_off"}, 8'(o_data), 8'd0);
      tick();
      tick();
      check({tag, "_off_hold"}, 8'(o_data), 8'd0);
      tick();
      expect_step({tag, "_hold"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_up[5]   = '{1, 2, 3, 0, 1};
      int exp_down[4] = '{3, 2, 1, 0};
      int exp_pp[7]   = '{1, 2, 3, 2, 1, 0, 1};
      logic [1:0] rsw;
      int rhold;

      do_reset(2, "por");

      foreach (exp_up[i]) begin
         do_step(2'b01, HOLD_FOREVER, "chase_up");
         check("chase_up_seq", sel(), 8'(exp_up[i]));
      end
      for (int i = 0; i < 3; i++) do_step(2'b01, HOLD_FOREVER, "chase_up_to0");
      check("at_pos0", sel(), 8'd0);

      foreach (exp_down[i]) begin
         do_step(2'b10, HOLD_FOREVER, "chase_down");
         check("chase_down_seq", sel(), 8'(exp_down[i]));
      end

      foreach (exp_pp[i]) begin
         do_step(2'b11, HOLD_FOREVER, "ping_pong");
         check("ping_pong_seq", sel(), 8'(exp_pp[i]));
      end

      do_step(2'b10, HOLD_FOREVER, "back_to0");
      do_step(2'b00, HOLD_FOREVER, "hold");
      do_step(2'b01, DEBOUNCE_LIMIT - 1, "glitch_a");
      do_step(2'b01, DEBOUNCE_LIMIT - 1, "glitch_b");
`ifndef DEMUX_RANDOM_MODE_EN
      check("glitch_hold_sel", sel(), 8'd0);
`endif
      do_step(2'b01, DEBOUNCE_LIMIT, "accept_4");
`ifndef DEMUX_RANDOM_MODE_EN
      check("accept_4_sel", sel(), 8'd1);
`endif
      do_step(2'b00, HOLD_FOREVER, "hold_again");

      for (int i = 0; i < 4 && m_pos != 2; i++) do_step(2'b01, HOLD_FOREVER, "seek_pos2");
      check("pre_reset_pos", sel(), 8'd2);
      do_reset(1, "mid");

      for (int i = 0; i < 24; i++) begin
         rsw   = 2'($urandom_range(0, 3));
         rhold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEBOUNCE_LIMIT - 1)) : HOLD_FOREVER;
         do_step(rsw, rhold, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
